// File: rtl/apb_otp_initiator.sv
// APB requester for the one-time-pad responder.
// Runs an optional key write (0x0), a data write (0x1) and a result read (0x2)
// for each client request. The read result, or a timeout error, is returned
// through a valid/ready response port.
module apb_otp_initiator #(
    parameter int WIDTH           = 128,
    parameter int TIMEOUT         = 16,
    parameter bit WR_IGNORE_READY = 1'b1
) (
    input  logic             pclk,
    input  logic             preset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_key,
    input  logic [WIDTH-1:0] req_data,
    input  logic             req_load_key,
    input  logic             req_priv,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic [31:0]      paddr,
    output logic             psel,
    output logic             penable,
    output logic             pwrite,
    output logic [2:0]       pprot,
    output logic [WIDTH-1:0] pwdata,
    input  logic [WIDTH-1:0] prdata,
    input  logic             pready
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, KEY_SETUP, KEY_ACCESS, DATA_SETUP,
        DATA_ACCESS, RD_SETUP, RD_ACCESS, RESP
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] key_q, data_q;
    logic             priv_q;
    logic [CNT_W-1:0] cnt;
    logic             in_access, in_setup, xfer_done, xfer_tmo;

    // Access-phase completion and timeout detection.
    always_comb begin
        in_access = (state == KEY_ACCESS) || (state == DATA_ACCESS) || (state == RD_ACCESS);
        in_setup  = (state == KEY_SETUP) || (state == DATA_SETUP) || (state == RD_SETUP);
        xfer_done = in_access && ((state != RD_ACCESS && WR_IGNORE_READY) || pready);
        xfer_tmo  = in_access && !xfer_done && (cnt == CNT_W'(TIMEOUT - 1));
    end

    // State register.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) state <= IDLE;
        else           state <= state_nxt;
    end

    // Next-state and APB/handshake outputs; bus fields only depend on state so
    // they change on setup entry and hold through access.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        pwrite    = 1'b0;
        paddr     = 32'h0;
        pprot     = 3'b000;
        pwdata    = '0;
        unique case (state)
            IDLE: begin
                // Held low while reset is asserted so every output reads zero.
                req_ready = preset_n;
                if (req_valid) state_nxt = req_load_key ? KEY_SETUP : DATA_SETUP;
            end
            KEY_SETUP, KEY_ACCESS: begin
                psel    = 1'b1;
                penable = (state == KEY_ACCESS);
                pwrite  = 1'b1;
                pprot   = {2'b00, priv_q};
                pwdata  = key_q;
                if (state == KEY_SETUP) state_nxt = KEY_ACCESS;
                else if (xfer_tmo)      state_nxt = RESP;
                else if (xfer_done)     state_nxt = DATA_SETUP;
            end
            DATA_SETUP, DATA_ACCESS: begin
                psel    = 1'b1;
                penable = (state == DATA_ACCESS);
                pwrite  = 1'b1;
                paddr   = 32'h1;
                pwdata  = data_q;
                if (state == DATA_SETUP) state_nxt = DATA_ACCESS;
                else if (xfer_tmo)       state_nxt = RESP;
                else if (xfer_done)      state_nxt = RD_SETUP;
            end
            RD_SETUP, RD_ACCESS: begin
                psel    = 1'b1;
                penable = (state == RD_ACCESS);
                paddr   = 32'h2;
                if (state == RD_SETUP)        state_nxt = RD_ACCESS;
                else if (xfer_tmo || xfer_done) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request capture; the client may change its inputs after acceptance.
    always_ff @(posedge pclk) begin
        if (state == IDLE && req_valid) begin
            key_q  <= req_key;
            data_q <= req_data;
            priv_q <= req_priv;
        end
    end

    // Access-cycle counter, cleared in every setup cycle.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n)                          cnt <= '0;
        else if (in_setup)                      cnt <= '0;
        else if (in_access && !xfer_done && !xfer_tmo) cnt <= cnt + 1'b1;
    end

    // Response registers, held stable through RESP.
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else if (state == RD_ACCESS && xfer_done) begin
            rsp_data <= prdata;
            rsp_err  <= 1'b0;
        end else if (xfer_tmo) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_apb_otp_initiator.sv
// Bench for apb_otp_initiator: OTP responder model, transfer monitor and
// per-scenario tests against a transaction-level reference model.
module tb_apb_otp_initiator;

    localparam int WIDTH   = 128;
    localparam int TIMEOUT = 4;

    logic             pclk = 1'b0;
    logic             preset_n;
    logic             req_valid, req_ready, req_load_key, req_priv;
    logic [WIDTH-1:0] req_key, req_data;
    logic             rsp_valid, rsp_ready, rsp_err;
    logic [WIDTH-1:0] rsp_data;
    logic [31:0]      paddr;
    logic             psel, penable, pwrite, pready;
    logic [2:0]       pprot;
    logic [WIDTH-1:0] pwdata, prdata;

    always #5 pclk = ~pclk;

    apb_otp_initiator #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .WR_IGNORE_READY(1'b1)) dut (
        .pclk(pclk), .preset_n(preset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key), .req_data(req_data),
        .req_load_key(req_load_key), .req_priv(req_priv),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite), .pprot(pprot),
        .pwdata(pwdata), .prdata(prdata), .pready(pready)
    );

    typedef struct {
        logic [31:0]      addr;
        logic [2:0]       prot;
        logic [WIDTH-1:0] wdata;
        logic             wr;
    } xfer_t;

    xfer_t xfers[$];
    xfer_t exp_x[$];

    int checks = 0;
    int passed = 0;

    // Responder: stores key/data on writes, reads return key ^ data.
    logic [WIDTH-1:0] key_store  = '0;
    logic [WIDTH-1:0] data_store = '0;
    int               acc_n      = 0;
    int               rd_waits   = 0;
    bit               stuck      = 1'b0;
    int               stab_err   = 0;
    logic [31:0]      s_addr = '0;
    logic [2:0]       s_prot = '0;
    logic [WIDTH-1:0] s_wdata = '0;
    logic             s_wr = 1'b0;

    assign pready = psel && penable && !pwrite && !stuck && (acc_n >= rd_waits);
    assign prdata = key_store ^ data_store;

    // Transfer monitor and responder storage.
    always @(posedge pclk) begin
        if (psel && !penable) begin
            s_addr <= paddr; s_prot <= pprot; s_wdata <= pwdata; s_wr <= pwrite;
        end
        if (psel && penable) begin
            if (paddr !== s_addr || pprot !== s_prot || pwdata !== s_wdata || pwrite !== s_wr)
                stab_err <= stab_err + 1;
            if (pwrite || pready) begin
                xfers.push_back('{addr: paddr, prot: pprot, wdata: pwdata, wr: pwrite});
                if (pwrite && paddr == 32'h0) key_store  <= pwdata;
                if (pwrite && paddr == 32'h1) data_store <= pwdata;
                acc_n <= 0;
            end else begin
                acc_n <= acc_n + 1;
            end
        end else begin
            acc_n <= 0;
        end
    end

    // Reference model: the pad key the responder should hold, and per request
    // the expected transfer list, response and latency.
    logic [WIDTH-1:0] model_key = '0;

    task automatic model_req(input logic [WIDTH-1:0] k, input logic [WIDTH-1:0] d,
                             input logic ld, input logic pv, input int waits, input bit stk,
                             output int lat, output logic [WIDTH-1:0] rd, output logic err);
        exp_x.delete();
        if (ld) begin
            exp_x.push_back('{addr: 32'h0, prot: {2'b00, pv}, wdata: k, wr: 1'b1});
            model_key = k;
        end
        exp_x.push_back('{addr: 32'h1, prot: 3'b000, wdata: d, wr: 1'b1});
        if (!stk) exp_x.push_back('{addr: 32'h2, prot: 3'b000, wdata: '0, wr: 1'b0});
        lat = (ld ? 7 : 5) + (stk ? TIMEOUT - 1 : waits);
        rd  = stk ? '0 : (model_key ^ d);
        err = stk;
    endtask

    function automatic bit log_match(int base);
        if (xfers.size() - base != exp_x.size()) return 1'b0;
        foreach (exp_x[i])
            if (xfers[base+i].addr !== exp_x[i].addr || xfers[base+i].prot !== exp_x[i].prot ||
                xfers[base+i].wdata !== exp_x[i].wdata || xfers[base+i].wr !== exp_x[i].wr)
                return 1'b0;
        return 1'b1;
    endfunction

    // Drives one request from a negedge and returns at the negedge where
    // rsp_valid is first seen (latency counted from the accept cycle).
    task automatic do_req(input logic [WIDTH-1:0] k, input logic [WIDTH-1:0] d,
                          input logic ld, input logic pv,
                          output int lat, output logic [WIDTH-1:0] rd, output logic err,
                          output logic bus_act);
        int g = 0;
        req_key = k; req_data = d; req_load_key = ld; req_priv = pv; req_valid = 1'b1;
        while (!req_ready && g < 50) begin @(negedge pclk); g++; end
        @(posedge pclk);
        @(negedge pclk);
        req_valid = 1'b0; req_key = ~k; req_data = ~d; req_load_key = ~ld; req_priv = ~pv;
        lat = 1;
        while (!rsp_valid && lat < 100) begin @(negedge pclk); lat++; end
        rd = rsp_data; err = rsp_err; bus_act = psel | penable;
    endtask

    task automatic test_reset();
        checks++;
        if ({req_ready, rsp_valid, rsp_err, rsp_data, psel, penable, pwrite, paddr, pprot, pwdata} !== '0)
            $display("FAIL reset_outputs: outputs nonzero during reset (req_ready=%0b psel=%0b rsp_valid=%0b)",
                     req_ready, psel, rsp_valid);
        else passed++;
        @(negedge pclk); preset_n = 1'b1; @(negedge pclk);
        checks++;
        if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %0b want 1", req_ready);
        else passed++;
    endtask

    task automatic test_key_load();
        int lat, elat; logic [WIDTH-1:0] rd, erd; logic err, eerr, ba; int base;
        base = xfers.size(); rd_waits = 0;
        model_req(128'hFF00, 128'h0F0F, 1'b1, 1'b1, 0, 1'b0, elat, erd, eerr);
        do_req(128'hFF00, 128'h0F0F, 1'b1, 1'b1, lat, rd, err, ba);
        checks++; if (rd !== 128'hF00F) $display("FAIL key_load_data: got %h want %h", rd, 128'hF00F); else passed++;
        checks++; if (err !== 1'b0) $display("FAIL key_load_err: got %0b want 0", err); else passed++;
        checks++; if (lat !== 7) $display("FAIL key_load_latency: got %0d want 7", lat); else passed++;
        @(negedge pclk);
        checks++; if (log_match(base) !== 1'b1) $display("FAIL key_load_xfers: got %0d transfers want %0d matching", xfers.size() - base, exp_x.size()); else passed++;
    endtask

    task automatic test_skip_key();
        int lat, elat; logic [WIDTH-1:0] rd, erd; logic err, eerr, ba; int base;
        model_req(128'h1234, 128'h5555, 1'b1, 1'b0, 0, 1'b0, elat, erd, eerr);
        do_req(128'h1234, 128'h5555, 1'b1, 1'b0, lat, rd, err, ba);
        @(negedge pclk);
        base = xfers.size();
        model_req(128'hDEAD, 128'h00FF, 1'b0, 1'b1, 0, 1'b0, elat, erd, eerr);
        do_req(128'hDEAD, 128'h00FF, 1'b0, 1'b1, lat, rd, err, ba);
        checks++; if (rd !== 128'h12CB) $display("FAIL skip_key_data: got %h want %h", rd, 128'h12CB); else passed++;
        checks++; if (lat !== 5) $display("FAIL skip_key_latency: got %0d want 5", lat); else passed++;
        @(negedge pclk);
        checks++; if (log_match(base) !== 1'b1) $display("FAIL skip_key_xfers: got %0d transfers want %0d matching", xfers.size() - base, exp_x.size()); else passed++;
    endtask

    task automatic test_wait_states();
        int lat, elat, se; logic [WIDTH-1:0] rd, erd; logic err, eerr, ba;
        logic [WIDTH-1:0] k, d;
        k = {$urandom, $urandom, $urandom, $urandom}; d = {$urandom, $urandom, $urandom, $urandom};
        se = stab_err; rd_waits = 3;
        model_req(k, d, 1'b1, 1'b0, 3, 1'b0, elat, erd, eerr);
        do_req(k, d, 1'b1, 1'b0, lat, rd, err, ba);
        checks++; if (lat !== 10) $display("FAIL wait_latency: got %0d want 10", lat); else passed++;
        checks++; if (rd !== erd) $display("FAIL wait_data: got %h want %h", rd, erd); else passed++;
        checks++; if (stab_err !== se) $display("FAIL wait_stability: got %0d violations want 0", stab_err - se); else passed++;
        @(negedge pclk); rd_waits = 0;
    endtask

    task automatic test_timeout();
        int lat, elat; logic [WIDTH-1:0] rd, erd; logic err, eerr, ba; int base;
        base = xfers.size(); stuck = 1'b1;
        model_req(128'hA5A5, 128'h3C3C, 1'b1, 1'b1, 0, 1'b1, elat, erd, eerr);
        do_req(128'hA5A5, 128'h3C3C, 1'b1, 1'b1, lat, rd, err, ba);
        checks++; if (lat !== 6 + TIMEOUT) $display("FAIL timeout_latency: got %0d want %0d", lat, 6 + TIMEOUT); else passed++;
        checks++; if (err !== 1'b1) $display("FAIL timeout_err: got %0b want 1", err); else passed++;
        checks++; if (rd !== '0) $display("FAIL timeout_data: got %h want 0", rd); else passed++;
        checks++; if (ba !== 1'b0) $display("FAIL timeout_psel: got %0b want 0", ba); else passed++;
        @(negedge pclk); stuck = 1'b0;
        checks++; if (log_match(base) !== 1'b1) $display("FAIL timeout_xfers: got %0d transfers want %0d matching", xfers.size() - base, exp_x.size()); else passed++;
    endtask

    task automatic test_backpressure();
        int lat, elat, bad, g; logic [WIDTH-1:0] rd, erd, rd0; logic err, eerr, ba;
        rsp_ready = 1'b0;
        model_req(128'h77, 128'h11, 1'b1, 1'b0, 0, 1'b0, elat, erd, eerr);
        do_req(128'h77, 128'h11, 1'b1, 1'b0, lat, rd0, err, ba);
        req_key = 128'h99; req_data = 128'hF0; req_load_key = 1'b0; req_priv = 1'b0; req_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_data !== rd0) bad++;
            @(negedge pclk);
        end
        checks++; if (bad !== 0) $display("FAIL bp_hold: got %0d bad cycles want 0", bad); else passed++;
        checks++; if (rd0 !== erd) $display("FAIL bp_data: got %h want %h", rd0, erd); else passed++;
        rsp_ready = 1'b1;
        @(negedge pclk);
        checks++; if ({req_ready, rsp_valid} !== 2'b10) $display("FAIL bp_release: got req_ready/rsp_valid=%b want 10", {req_ready, rsp_valid}); else passed++;
        @(negedge pclk); req_valid = 1'b0;
        checks++; if ({psel, penable, paddr} !== {1'b1, 1'b0, 32'h1}) $display("FAIL bp_accept: got psel=%0b penable=%0b paddr=%h want 1 0 1", psel, penable, paddr); else passed++;
        model_req(128'h99, 128'hF0, 1'b0, 1'b0, 0, 1'b0, elat, erd, eerr);
        g = 0;
        while (!rsp_valid && g < 50) begin @(negedge pclk); g++; end
        checks++; if (rsp_data !== erd) $display("FAIL bp_second_data: got %h want %h", rsp_data, erd); else passed++;
        @(negedge pclk);
    endtask

    task automatic test_reset_midop();
        int g, seen;
        logic [WIDTH-1:0] k;
        k = {$urandom, $urandom, $urandom, $urandom};
        req_key = k; req_data = 128'h5; req_load_key = 1'b1; req_priv = 1'b1; req_valid = 1'b1;
        g = 0;
        while (!req_ready && g < 50) begin @(negedge pclk); g++; end
        @(posedge pclk); @(negedge pclk); req_valid = 1'b0;
        repeat (3) @(negedge pclk);
        checks++; if ({psel, penable, paddr} !== {1'b1, 1'b1, 32'h1}) $display("FAIL midop_data_access: got psel=%0b penable=%0b paddr=%h want 1 1 1", psel, penable, paddr); else passed++;
        model_key = k;
        preset_n = 1'b0; #1;
        checks++;
        if ({req_ready, rsp_valid, rsp_err, rsp_data, psel, penable, pwrite, paddr, pprot, pwdata} !== '0)
            $display("FAIL midop_reset_outputs: got psel=%0b penable=%0b pwrite=%0b paddr=%h want all 0", psel, penable, pwrite, paddr);
        else passed++;
        @(negedge pclk); @(negedge pclk); preset_n = 1'b1; @(negedge pclk);
        checks++; if (req_ready !== 1'b1) $display("FAIL midop_req_ready: got %0b want 1", req_ready); else passed++;
        seen = 0;
        for (int i = 0; i < 10; i++) begin if (rsp_valid !== 1'b0 || psel !== 1'b0) seen++; @(negedge pclk); end
        checks++; if (seen !== 0) $display("FAIL midop_no_rsp: got %0d active cycles want 0", seen); else passed++;
    endtask

    task automatic test_random();
        int lat, elat, base, se, w; logic [WIDTH-1:0] rd, erd, k, d; logic err, eerr, ba, ld, pv; bit stk;
        for (int n = 0; n < 25; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            d = ($urandom_range(0, 5) == 0) ? '0 : {$urandom, $urandom, $urandom, $urandom};
            ld = 1'($urandom_range(0, 1)); pv = 1'($urandom_range(0, 1));
            w = $urandom_range(0, 3); stk = ($urandom_range(0, 5) == 0);
            rd_waits = w; stuck = stk; base = xfers.size(); se = stab_err;
            model_req(k, d, ld, pv, w, stk, elat, erd, eerr);
            do_req(k, d, ld, pv, lat, rd, err, ba);
            checks++; if (lat !== elat) $display("FAIL rand%0d_latency: got %0d want %0d", n, lat, elat); else passed++;
            checks++; if ({err, rd} !== {eerr, erd}) $display("FAIL rand%0d_rsp: got err=%0b data=%h want err=%0b data=%h", n, err, rd, eerr, erd); else passed++;
            @(negedge pclk);
            checks++; if (log_match(base) !== 1'b1 || stab_err !== se) $display("FAIL rand%0d_xfers: got %0d transfers %0d violations want %0d transfers 0 violations", n, xfers.size() - base, stab_err - se, exp_x.size()); else passed++;
            stuck = 1'b0; rd_waits = 0;
        end
    endtask

    initial begin
        preset_n = 1'b0; req_valid = 1'b0; req_key = '0; req_data = '0;
        req_load_key = 1'b0; req_priv = 1'b0; rsp_ready = 1'b1;
        #1;
        test_reset();
        test_key_load();
        test_skip_key();
        test_wait_states();
        test_timeout();
        test_backpressure();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/apb_otp_initiator.md
# apb_otp_initiator

APB requester that drives the one-time-pad APB responder on behalf of a local client. A client request carries a key, plaintext data and privilege flag. The block sequences the APB transfers: optional privileged key write to 0x0, data write to 0x1, then result read from 0x2. It returns the read data, or an error on timeout, through a valid/ready response port. It sits between security-test stimulus logic and the OTP responder on the same pclk domain.

## Interface
- WIDTH, 128, width of key/data/pwdata/prdata
- TIMEOUT, 16, max access-phase cycles a read waits for pready (≥1)
- WR_IGNORE_READY, 1, 1: write access phase completes after one cycle regardless of pready; 0: writes wait for pready with the same TIMEOUT
- pclk  in  1  clock
- preset_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  client request valid
- req_ready  out  1  block can accept request (high only in IDLE)
- req_key  in  WIDTH  key value
- req_data  in  WIDTH  plaintext value
- req_load_key  in  1  1: perform key write; 0: skip it
- req_priv  in  1  driven onto pprot[0] during key write
- rsp_valid  out  1  response valid
- rsp_ready  in  1  client accepts response
- rsp_data  out  WIDTH  read result; 0 on error
- rsp_err  out  1  transfer timed out
- paddr  out  32  APB address
- psel, penable, pwrite  out  1 each  APB controls
- pprot  out  3  APB protection
- pwdata  out  WIDTH  APB write data
- prdata  in  WIDTH  APB read data
- pready  in  1  APB ready

## Operation
- States: IDLE, KEY_SETUP, KEY_ACCESS, DATA_SETUP, DATA_ACCESS, RD_SETUP, RD_ACCESS, RESP.
- IDLE: req_ready=1. On req_valid, capture key/data/load_key/priv into internal registers; go to KEY_SETUP if load_key else DATA_SETUP. Request inputs are don't-care after acceptance.
- Key transfer: paddr=0x0, pwrite=1, pprot={2'b00,priv}, pwdata=key.
- Data transfer: paddr=0x1, pwrite=1, pprot=3'b000, pwdata=data. Issued even when data==0; no special handling.
- Read transfer: paddr=0x2, pwrite=0, pprot=3'b000, pwdata=0.
- *_SETUP: psel=1, penable=0; next cycle always *_ACCESS.
- *_ACCESS: psel=1, penable=1. Completion rules:
  - Write with WR_IGNORE_READY=1: completes after one cycle.
  - Read, or write with WR_IGNORE_READY=0: completes in the first cycle pready=1.
- Back-to-back transfers: psel stays high from access into the next setup. paddr/pwrite/pprot/pwdata change only on setup entry and are held through access.
- Read completion: register prdata into rsp_data, rsp_err=0, go to RESP.
- Timeout: an access-cycle counter increments each access cycle without completion. When it reaches TIMEOUT:
  - Abort the transfer. Go to RESP with rsp_err=1, rsp_data=0.
  - Skip the remaining transfers.
  - Counter clears on every setup entry.
- RESP: psel=penable=0, rsp_valid=1; rsp_data/rsp_err held stable until rsp_ready=1, then IDLE. No new request is accepted in RESP.
- Outside any transfer, paddr, pwrite, pprot and pwdata are driven 0.

## Timing
- Reset (async assert, sync-release use): state=IDLE; req_ready=1 after release; rsp_valid=0, rsp_data=0, rsp_err=0, psel=penable=pwrite=0, paddr=0, pprot=0, pwdata=0; counter=0.
- Reset mid-transfer aborts immediately; no response is produced.
- Cycle numbering, accept = cycle 0, zero-wait reads:
  - load_key=1: key setup 1, key access 2, data setup 3, data access 4, read setup 5, read access 6, rsp_valid from 7. Latency 7.
  - load_key=0: rsp_valid from 5.
- Each read wait state adds 1 cycle.
- Timeout: with pready stuck 0, rsp_valid rises TIMEOUT cycles after read-access entry, after the final access cycle.
- rsp_valid && rsp_ready in cycle n → req_ready=1 in cycle n+1.

## Test plan
- Key load, no waits: key=0xFF00, data=0x0F0F, load_key=1, priv=1. Responder model: pready=1 on reads only. Required: paddr sequence 0,1,2 with pprot 001,000,000; rsp_data=0xF00F, rsp_err=0; rsp_valid at cycle 7.
- Skip key: a first request loads key 0x1234; a second request with load_key=0, data=0x00FF. Required: no paddr=0 transfer; rsp_data=0x12CB; rsp_valid at cycle 5.
- Read wait states: pready held low 3 read-access cycles. Required: psel/penable/paddr=2 stable throughout; rsp_valid at cycle 10; data correct.
- Timeout: TIMEOUT=4, pready stuck 0. Required: 4 read-access cycles, then rsp_err=1, rsp_data=0, psel=0.
- Response backpressure plus new request: rsp_ready low 5 cycles with req_valid high. Required: req_ready=0 and rsp_data stable throughout; accept occurs the cycle after the handshake.
- Reset mid-op: assert preset_n low during DATA_ACCESS. Required: all outputs 0 immediately; after release, req_ready=1 and no rsp_valid.
